// File: rtl/memu_pkg.sv
// memu_pkg: shared load byte-mask constants and the decoded load kind.
// The `MEM_RE_* defines are shared with EX so both stages agree on mask encoding.
// No ports; imported by memu and memu_load_align.
`ifndef MEM_RE_DEFS
`define MEM_RE_DEFS
`define MEM_RE_W  4'b1111
`define MEM_RE_H0 4'b0011
`define MEM_RE_H1 4'b0110
`define MEM_RE_H2 4'b1100
`define MEM_RE_B0 4'b0001
`define MEM_RE_B1 4'b0010
`define MEM_RE_B2 4'b0100
`define MEM_RE_B3 4'b1000
`endif

package memu_pkg;

   localparam logic [3:0] MemReNone = 4'b0000;

   typedef enum logic [2:0] {
      LdPass,
      LdWord,
      LdHalf,
      LdByte,
      LdBad
   } ld_kind_e;

endpackage

// File: rtl/memu_load_align.sv
// memu_load_align: combinational load alignment (the load_align unit).
// Selects the word/halfword/byte lane named by mem_re from rdata and
// sign- or zero-extends it to XLEN; mask 0000 passes alu_res through and
// any unrecognised mask yields 0.
// Ports:
//   mem_re     in  4     load byte mask
//   mem_signal in  1     1 = sign-extend, 0 = zero-extend
//   rdata      in  XLEN  raw read data
//   alu_res    in  XLEN  non-load result
//   wdata      out XLEN  aligned / extended writeback data
module memu_load_align
   import memu_pkg::*;
#(
   parameter int unsigned XLEN = 32
) (
   input  logic [3:0]      mem_re,
   input  logic            mem_signal,
   input  logic [XLEN-1:0] rdata,
   input  logic [XLEN-1:0] alu_res,
   output logic [XLEN-1:0] wdata
);

   ld_kind_e   kind;
   logic [1:0] lane;
   logic [31:0] shifted;
   logic [15:0] half;
   logic [7:0]  byt;

   always_comb begin
      kind = LdBad;
      lane = 2'd0;
      case (mem_re)
         MemReNone:  kind = LdPass;
         `MEM_RE_W:  kind = LdWord;
         `MEM_RE_H0: begin kind = LdHalf; lane = 2'd0; end
         `MEM_RE_H1: begin kind = LdHalf; lane = 2'd1; end
         `MEM_RE_H2: begin kind = LdHalf; lane = 2'd2; end
         `MEM_RE_B0: begin kind = LdByte; lane = 2'd0; end
         `MEM_RE_B1: begin kind = LdByte; lane = 2'd1; end
         `MEM_RE_B2: begin kind = LdByte; lane = 2'd2; end
         `MEM_RE_B3: begin kind = LdByte; lane = 2'd3; end
         default:    kind = LdBad;
      endcase
   end

   assign shifted = rdata[31:0] >> {lane, 3'b000};
   assign half    = shifted[15:0];
   assign byt     = shifted[7:0];

   always_comb begin
      wdata = '0;
      case (kind)
         LdPass:  wdata = alu_res;
         LdWord:  wdata = mem_signal ? XLEN'($signed(rdata[31:0])) : XLEN'(rdata[31:0]);
         LdHalf:  wdata = mem_signal ? XLEN'($signed(half)) : XLEN'(half);
         LdByte:  wdata = mem_signal ? XLEN'($signed(byt)) : XLEN'(byt);
         default: wdata = '0;
      endcase
   end

endmodule

// File: rtl/memu.sv
// memu: MEM pipeline stage.
// Registers the EX packet behind a valid/ready handshake, captures the
// synchronous dsram read data in the first cycle after capture (holding it
// across WB stalls), aligns it through memu_load_align and presents the
// writeback packet to WB.
// Optional feature macro: MEMU_FWD_EN adds the ID bypass outputs
// mem_fwd_valid / mem_fwd_waddr / mem_fwd_wdata.
// Ports:
//   clk, rst (async, active-low)
//   ex_to_mem_*   EX packet in, o_mem_ready handshake out
//   dsram_rdata   read data, valid the cycle after the EX request
//   i_wb_ready    WB back-pressure
//   mem_to_wb_*   writeback packet out
//   memu_active   stage holds a valid instruction
module memu
   import memu_pkg::*;
#(
   parameter int unsigned XLEN = 32,
   parameter int unsigned REGW = 5
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            ex_to_mem_valid,
   output logic            o_mem_ready,
   input  logic            ex_to_mem_mem_signal,
   input  logic [3:0]      ex_to_mem_mem_re,
   input  logic [XLEN-1:0] ex_to_mem_alu_res,
   input  logic [REGW-1:0] ex_to_mem_rf_waddr,
   input  logic            ex_to_mem_rf_we,
   input  logic [XLEN-1:0] ex_to_mem_pc,
   input  logic [31:0]     ex_to_mem_inst,
   input  logic [XLEN-1:0] dsram_rdata,
   input  logic            i_wb_ready,
   output logic            mem_to_wb_valid,
   output logic [XLEN-1:0] mem_to_wb_rf_wdata,
   output logic [REGW-1:0] mem_to_wb_rf_waddr,
   output logic            mem_to_wb_rf_we,
   output logic [XLEN-1:0] mem_to_wb_pc,
   output logic [31:0]     mem_to_wb_inst,
`ifdef MEMU_FWD_EN
   output logic            mem_fwd_valid,
   output logic [REGW-1:0] mem_fwd_waddr,
   output logic [XLEN-1:0] mem_fwd_wdata,
`endif
   output logic            memu_active
);

   logic            mem_valid;
   logic            first;
   logic            hold_vld;
   logic [XLEN-1:0] rdata_hold;
   logic            mem_signal;
   logic [3:0]      mem_re;
   logic [XLEN-1:0] alu_res;
   logic [REGW-1:0] rf_waddr;
   logic            rf_we;
   logic [XLEN-1:0] pc;
   logic [31:0]     inst;
   logic [XLEN-1:0] rdata_src;
   logic [XLEN-1:0] rf_wdata;
   logic            capture;

   assign o_mem_ready = !mem_valid | i_wb_ready;
   assign capture     = ex_to_mem_valid & o_mem_ready;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mem_valid  <= 1'b0;
         first      <= 1'b0;
         hold_vld   <= 1'b0;
         rdata_hold <= '0;
         mem_signal <= 1'b0;
         mem_re     <= '0;
         alu_res    <= '0;
         rf_waddr   <= '0;
         rf_we      <= 1'b0;
         pc         <= '0;
         inst       <= '0;
      end else begin
         if (capture) begin
            mem_valid  <= 1'b1;
            first      <= 1'b1;
            hold_vld   <= 1'b0;
            mem_signal <= ex_to_mem_mem_signal;
            mem_re     <= ex_to_mem_mem_re;
            alu_res    <= ex_to_mem_alu_res;
            rf_waddr   <= ex_to_mem_rf_waddr;
            rf_we      <= ex_to_mem_rf_we;
            pc         <= ex_to_mem_pc;
            inst       <= ex_to_mem_inst;
         end else begin
            if (i_wb_ready) begin
               mem_valid <= 1'b0;
            end
            // The dsram only drives valid data for one cycle; keep a copy for stalls.
            if (first) begin
               rdata_hold <= dsram_rdata;
               first      <= 1'b0;
               hold_vld   <= 1'b1;
            end
         end
      end
   end

   always_comb begin
      rdata_src = '0;
      if (first) begin
         rdata_src = dsram_rdata;
      end else if (hold_vld) begin
         rdata_src = rdata_hold;
      end
   end

   memu_load_align #(
      .XLEN (XLEN)
   ) u_load_align (
      .mem_re     (mem_re),
      .mem_signal (mem_signal),
      .rdata      (rdata_src),
      .alu_res    (alu_res),
      .wdata      (rf_wdata)
   );

   assign mem_to_wb_valid    = mem_valid;
   assign mem_to_wb_rf_wdata = rf_wdata;
   assign mem_to_wb_rf_waddr = rf_waddr;
   assign mem_to_wb_rf_we    = mem_valid & rf_we;
   assign mem_to_wb_pc       = pc;
   assign mem_to_wb_inst     = inst;
   assign memu_active        = mem_valid;

`ifdef MEMU_FWD_EN
   assign mem_fwd_valid = mem_valid & rf_we & (rf_waddr != '0);
   assign mem_fwd_waddr = rf_waddr;
   assign mem_fwd_wdata = rf_wdata;
`endif

endmodule
